pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 44 ++++
 rtl/pipeline_hazard_ctrl_if.sv | 43 ++++
 rtl/pipeline_hazard_ctrl_load_use_detect.sv | 20 ++
 rtl/pipeline_hazard_ctrl.sv | 156 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: state encoding,
// parameter defaults, register-index width and the stall/flush control bundle.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W           = 5;
    localparam int unsigned LOAD_LAT_DEF    = 1;
    localparam int unsigned MEM_TIMEOUT_DEF = 255;
    localparam int unsigned WAIT_W          = 8;
    localparam int unsigned STALL_CNT_W     = 16;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_HALT     = 2'd3
    } hz_state_t;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic ctrl_stall;
        logic ex_mem_stall;
        logic id_ex_bubble;
        logic mem_wb_bubble;
        logic if_id_flush;
        logic pc_sel_target;
    } hz_ctrl_t;

    // Control bundles for each kind of pipeline intervention
    localparam hz_ctrl_t CTRL_NONE     = 8'b0000_0000;
    localparam hz_ctrl_t CTRL_LOAD_USE = 8'b1100_1000;
    localparam hz_ctrl_t CTRL_MEM_WAIT = 8'b1111_0100;
    localparam hz_ctrl_t CTRL_BRANCH   = 8'b0000_1011;
    localparam hz_ctrl_t CTRL_HALT     = 8'b1111_0000;

    function automatic logic [STALL_CNT_W-1:0] sat_inc16(input logic [STALL_CNT_W-1:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller signal bundle: pipeline status in, stall/flush/bubble
// controls and status out. The pipeline side is master, the controller slave.
interface pipeline_hazard_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic             ID_EX_MemRead;
    logic [REG_W-1:0] ID_EX_Rd;
    logic [REG_W-1:0] IF_ID_Rs1;
    logic [REG_W-1:0] IF_ID_Rs2;
    logic             branch_taken;
    logic             EX_MEM_MemRead;
    logic             EX_MEM_MemWrite;
    logic             dmem_ready;

    logic             PC_Stall;
    logic             IF_ID_Stall;
    logic             Control_Sig_Stall;
    logic             EX_MEM_Stall;
    logic             ID_EX_Bubble;
    logic             MEM_WB_Bubble;
    logic             IF_ID_Flush;
    logic             PC_Sel_Target;
    logic             mem_timeout;
    logic [15:0]      stall_cnt;
    logic [1:0]       state;

    modport master (
        output ID_EX_MemRead, ID_EX_Rd, IF_ID_Rs1, IF_ID_Rs2, branch_taken,
               EX_MEM_MemRead, EX_MEM_MemWrite, dmem_ready,
        input  PC_Stall, IF_ID_Stall, Control_Sig_Stall, EX_MEM_Stall,
               ID_EX_Bubble, MEM_WB_Bubble, IF_ID_Flush, PC_Sel_Target,
               mem_timeout, stall_cnt, state
    );

    modport slave (
        input  ID_EX_MemRead, ID_EX_Rd, IF_ID_Rs1, IF_ID_Rs2, branch_taken,
               EX_MEM_MemRead, EX_MEM_MemWrite, dmem_ready,
        output PC_Stall, IF_ID_Stall, Control_Sig_Stall, EX_MEM_Stall,
               ID_EX_Bubble, MEM_WB_Bubble, IF_ID_Flush, PC_Sel_Target,
               mem_timeout, stall_cnt, state
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use detector: a load in EX writing a non-zero register
// that the instruction in ID reads.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic             i_mem_read,
    input  logic [REG_W-1:0] i_rd,
    input  logic [REG_W-1:0] i_rs1,
    input  logic [REG_W-1:0] i_rs2,
    output logic             o_hazard
);

    logic w_rd_nonzero;
    logic w_src_match;

    assign w_rd_nonzero = (i_rd != {REG_W{1'b0}});
    assign w_src_match  = (i_rd == i_rs1) || (i_rd == i_rs2);
    assign o_hazard     = i_mem_read & w_rd_nonzero & w_src_match;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: serves memory waits, taken branches and
// load-use hazards, with a memory-timeout halt and a saturating stall counter.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_LAT    = LOAD_LAT_DEF,
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  hz
);

    localparam logic [1:0]      LU_INIT     = 2'(LOAD_LAT - 32'd1);
    localparam bit              LU_MULTI    = (LOAD_LAT > 32'd1);
    localparam logic [WAIT_W:0] TIMEOUT_LIM = 9'(MEM_TIMEOUT);

    hz_state_t              r_state;
    logic [WAIT_W-1:0]      r_wait_cnt;
    logic [1:0]             r_lu_cnt;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    hz_state_t              w_state_nxt;
    logic [WAIT_W-1:0]      w_wait_nxt;
    logic [1:0]             w_lu_nxt;
    logic [WAIT_W:0]        w_wait_inc;
    hz_ctrl_t               w_ctrl;
    hz_ctrl_t               w_ctrl_o;
    logic                   w_lu_hazard;
    logic                   w_mem_wait;

    load_use_detect u_load_use_detect (
        .i_mem_read (hz.ID_EX_MemRead),
        .i_rd       (hz.ID_EX_Rd),
        .i_rs1      (hz.IF_ID_Rs1),
        .i_rs2      (hz.IF_ID_Rs2),
        .o_hazard   (w_lu_hazard)
    );

    assign w_mem_wait = (hz.EX_MEM_MemRead | hz.EX_MEM_MemWrite) & ~hz.dmem_ready;
    assign w_wait_inc = {1'b0, r_wait_cnt} + 9'd1;

    // Next-state, counter-next and pipeline control decode
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_lu_nxt    = r_lu_cnt;
        w_ctrl      = CTRL_NONE;
        case (r_state)
            ST_RUN: begin
                if (w_mem_wait) begin
                    w_ctrl      = CTRL_MEM_WAIT;
                    w_state_nxt = ST_MEM_WAIT;
                    w_wait_nxt  = 8'd1;
                    w_lu_nxt    = 2'd0;
                end else if (hz.branch_taken) begin
                    w_ctrl   = CTRL_BRANCH;
                    w_lu_nxt = 2'd0;
                end else if (w_lu_hazard) begin
                    w_ctrl = CTRL_LOAD_USE;
                    if (LU_MULTI) begin
                        w_state_nxt = ST_LU_STALL;
                        w_lu_nxt    = LU_INIT;
                    end else begin
                        w_lu_nxt = 2'd0;
                    end
                end else begin
                    w_lu_nxt = 2'd0;
                end
            end
            ST_LU_STALL: begin
                // A memory wait drops whatever load-use cycles remain
                if (w_mem_wait) begin
                    w_ctrl      = CTRL_MEM_WAIT;
                    w_state_nxt = ST_MEM_WAIT;
                    w_wait_nxt  = 8'd1;
                    w_lu_nxt    = 2'd0;
                end else begin
                    w_ctrl   = CTRL_LOAD_USE;
                    w_lu_nxt = r_lu_cnt - 2'd1;
                    if (r_lu_cnt <= 2'd1) begin
                        w_state_nxt = ST_RUN;
                        w_lu_nxt    = 2'd0;
                    end else begin
                        w_state_nxt = ST_LU_STALL;
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (hz.dmem_ready) begin
                    w_state_nxt = ST_RUN;
                    w_wait_nxt  = 8'd0;
                end else begin
                    // wait_cnt counts every not-ready cycle, including the entry cycle
                    w_ctrl     = CTRL_MEM_WAIT;
                    w_wait_nxt = w_wait_inc[WAIT_W-1:0];
                    if (w_wait_inc >= TIMEOUT_LIM) begin
                        w_state_nxt = ST_HALT;
                    end else begin
                        w_state_nxt = ST_MEM_WAIT;
                    end
                end
            end
            ST_HALT: begin
                w_ctrl      = CTRL_HALT;
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_wait_nxt  = 8'd0;
                w_lu_nxt    = 2'd0;
            end
        endcase
    end

    // Reset forces every control low even though the outputs are combinational
    always_comb begin
        if (rst) begin
            w_ctrl_o = CTRL_NONE;
        end else begin
            w_ctrl_o = w_ctrl;
        end
    end

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= 8'd0;
            r_lu_cnt    <= 2'd0;
            r_stall_cnt <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_lu_cnt   <= w_lu_nxt;
            if (w_ctrl_o.pc_stall) begin
                r_stall_cnt <= sat_inc16(r_stall_cnt);
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
        end
    end

    assign hz.PC_Stall          = w_ctrl_o.pc_stall;
    assign hz.IF_ID_Stall       = w_ctrl_o.if_id_stall;
    assign hz.Control_Sig_Stall = w_ctrl_o.ctrl_stall;
    assign hz.EX_MEM_Stall      = w_ctrl_o.ex_mem_stall;
    assign hz.ID_EX_Bubble      = w_ctrl_o.id_ex_bubble;
    assign hz.MEM_WB_Bubble     = w_ctrl_o.mem_wb_bubble;
    assign hz.IF_ID_Flush       = w_ctrl_o.if_id_flush;
    assign hz.PC_Sel_Target     = w_ctrl_o.pc_sel_target;
    assign hz.mem_timeout       = (r_state == ST_HALT) && !rst;
    assign hz.stall_cnt         = r_stall_cnt;
    assign hz.state             = r_state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: two instances (LOAD_LAT=1/MEM_TIMEOUT=255
// and LOAD_LAT=3/MEM_TIMEOUT=3) driven by directed vectors with hand-computed results.
module tb_pipeline_hazard_ctrl;

    // Flag order: PC, IF_ID, CTRL, EX_MEM stall, ID_EX bub, MEM_WB bub, flush, sel_target, timeout
    localparam logic [8:0] F_NONE = 9'b000000000;
    localparam logic [8:0] F_LU   = 9'b110010000;
    localparam logic [8:0] F_MW   = 9'b111101000;
    localparam logic [8:0] F_BR   = 9'b000010110;
    localparam logic [8:0] F_HALT = 9'b111100001;

    typedef struct {
        bit          sel;
        logic [8:0]  f;
        logic [1:0]  st;
        logic [15:0] cnt;
        string       nm;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t q[$];

    pipeline_hazard_ctrl_if if_a ();
    pipeline_hazard_ctrl_if if_b ();

    pipeline_hazard_ctrl #(.LOAD_LAT(1), .MEM_TIMEOUT(255)) dut_a (
        .clk (clk),
        .rst (rst),
        .hz  (if_a)
    );

    pipeline_hazard_ctrl #(.LOAD_LAT(3), .MEM_TIMEOUT(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .hz  (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: mid-cycle, pop one expectation and compare against the tagged instance
    exp_t        m_e;
    logic [8:0]  m_f;
    logic [1:0]  m_st;
    logic [15:0] m_cnt;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            m_e = q.pop_front();
            if (m_e.sel) begin
                m_f   = {if_b.PC_Stall, if_b.IF_ID_Stall, if_b.Control_Sig_Stall, if_b.EX_MEM_Stall,
                         if_b.ID_EX_Bubble, if_b.MEM_WB_Bubble, if_b.IF_ID_Flush, if_b.PC_Sel_Target,
                         if_b.mem_timeout};
                m_st  = if_b.state;
                m_cnt = if_b.stall_cnt;
            end else begin
                m_f   = {if_a.PC_Stall, if_a.IF_ID_Stall, if_a.Control_Sig_Stall, if_a.EX_MEM_Stall,
                         if_a.ID_EX_Bubble, if_a.MEM_WB_Bubble, if_a.IF_ID_Flush, if_a.PC_Sel_Target,
                         if_a.mem_timeout};
                m_st  = if_a.state;
                m_cnt = if_a.stall_cnt;
            end
            checks = checks + 1;
            if ({m_f, m_st, m_cnt} !== {m_e.f, m_e.st, m_e.cnt}) begin
                failures = failures + 1;
                $display("FAIL %s: got flags=%b state=%0d stall_cnt=%0d, expected flags=%b state=%0d stall_cnt=%0d",
                         m_e.nm, m_f, m_st, m_cnt, m_e.f, m_e.st, m_e.cnt);
            end
        end
    end

    task automatic set_if(input bit s, input bit mrd, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input bit br, input bit mr, input bit mw, input bit rdy);
        if (s) begin
            if_b.ID_EX_MemRead = mrd;  if_b.ID_EX_Rd = rd;  if_b.IF_ID_Rs1 = rs1;  if_b.IF_ID_Rs2 = rs2;
            if_b.branch_taken = br;    if_b.EX_MEM_MemRead = mr;  if_b.EX_MEM_MemWrite = mw;
            if_b.dmem_ready = rdy;
        end else begin
            if_a.ID_EX_MemRead = mrd;  if_a.ID_EX_Rd = rd;  if_a.IF_ID_Rs1 = rs1;  if_a.IF_ID_Rs2 = rs2;
            if_a.branch_taken = br;    if_a.EX_MEM_MemRead = mr;  if_a.EX_MEM_MemWrite = mw;
            if_a.dmem_ready = rdy;
        end
    endtask

    // One cycle: drive the selected instance, idle the other, queue the expected response
    task automatic step(input bit s, input bit r, input bit mrd, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input bit br, input bit mr,
                        input bit mw, input bit rdy, input logic [8:0] f, input logic [1:0] st,
                        input logic [15:0] cnt, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        set_if(!s, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        set_if(s, mrd, rd, rs1, rs2, br, mr, mw, rdy);
        e.sel = s;  e.f = f;  e.st = st;  e.cnt = cnt;  e.nm = nm;
        q.push_back(e);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        set_if(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        set_if(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset holds everything quiet even with every hazard input active
        step(0, 1, 1, 5'd5, 5'd0, 5'd5, 1, 1, 0, 0, F_NONE, 2'd0, 16'd0, "rst_a_quiet");
        step(1, 1, 1, 5'd5, 5'd0, 5'd5, 1, 1, 0, 0, F_NONE, 2'd0, 16'd0, "rst_b_quiet");

        // Instance A: LOAD_LAT=1, MEM_TIMEOUT=255
        step(0, 0, 1, 5'd5, 5'd0, 5'd5, 0, 0, 0, 1, F_LU,   2'd0, 16'd0, "lu_rs2");
        step(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, F_NONE, 2'd0, 16'd1, "lu_one_cycle");
        step(0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, F_NONE, 2'd0, 16'd1, "lu_rd_zero");
        step(0, 0, 1, 5'd7, 5'd7, 5'd3, 0, 0, 0, 1, F_LU,   2'd0, 16'd1, "lu_rs1");
        step(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, F_NONE, 2'd0, 16'd2, "lu_rs1_done");
        step(0, 0, 0, 5'd7, 5'd7, 5'd3, 0, 0, 0, 1, F_NONE, 2'd0, 16'd2, "no_memread");
        step(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, F_MW,   2'd0, 16'd2, "mw_enter");
        step(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, F_MW,   2'd2, 16'd3, "mw_wait1");
        step(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, F_MW,   2'd2, 16'd4, "mw_wait2");
        step(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, F_MW,   2'd2, 16'd5, "mw_wait3");
        step(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1, F_NONE, 2'd2, 16'd6, "mw_ready");
        step(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, F_NONE, 2'd0, 16'd6, "mw_back_run");
        step(0, 0, 1, 5'd5, 5'd0, 5'd5, 1, 0, 0, 1, F_BR,   2'd0, 16'd6, "br_over_lu");
        step(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, F_NONE, 2'd0, 16'd6, "br_one_cycle");
        step(0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 1, 0, F_MW,   2'd0, 16'd6, "mw_over_br");
        step(0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 1, 1, F_NONE, 2'd2, 16'd7, "mw_br_ready");
        step(0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 1, F_BR,   2'd0, 16'd7, "br_served");
        step(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, F_NONE, 2'd0, 16'd7, "a_idle");

        // Instance B: LOAD_LAT=3, MEM_TIMEOUT=3
        step(1, 0, 1, 5'd4, 5'd4, 5'd0, 0, 0, 0, 1, F_LU,   2'd0, 16'd0, "b_lu_enter");
        step(1, 0, 1, 5'd4, 5'd4, 5'd0, 0, 0, 1, 0, F_MW,   2'd1, 16'd1, "b_mw_preempt");
        step(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, F_NONE, 2'd2, 16'd2, "b_mw_ready");
        step(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, F_NONE, 2'd0, 16'd2, "b_no_residual");
        step(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, F_NONE, 2'd0, 16'd2, "b_idle");
        step(1, 0, 1, 5'd4, 5'd4, 5'd0, 0, 0, 0, 1, F_LU,   2'd0, 16'd2, "b_lu3_c1");
        step(1, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 1, F_LU,   2'd1, 16'd3, "b_lu3_c2");
        step(1, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 1, F_LU,   2'd1, 16'd4, "b_lu3_c3");
        step(1, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 1, F_BR,   2'd0, 16'd5, "b_br_after_lu");
        step(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, F_NONE, 2'd0, 16'd5, "b_idle2");
        step(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, F_MW,   2'd0, 16'd5, "b_to_c1");
        step(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, F_MW,   2'd2, 16'd6, "b_to_c2");
        step(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, F_MW,   2'd2, 16'd7, "b_to_c3");
        step(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, F_HALT, 2'd3, 16'd8, "b_halt");
        step(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, F_HALT, 2'd3, 16'd9, "b_halt_sticky");
        step(1, 1, 1, 5'd4, 5'd4, 5'd0, 1, 1, 0, 0, F_NONE, 2'd0, 16'd0, "b_rst_pulse");
        step(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, F_NONE, 2'd0, 16'd0, "b_after_rst");

        // Bounded drain of the scoreboard
        for (int i = 0; i < 8 && q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        checks = checks + 1;
        if (q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
